ub_affine_sched_ctrl: RTL and testbench

- Affine schedule controller driving one unified-buffer port (write or read), e.g. op_*_write_wen / op_*_read_ren plus op_*_ctrl_vars.
- Walks a DIMS-deep loop nest and fires one access per point at cycle offset + sum(stride_k * idx_k), counted from the last flush.
- One instance per UB port; all instances share clk, rst_n, flush, en.

---
 rtl/ub_affine_sched_ctrl.sv | 126 ++++++++++++
 tb/tb_ub_affine_sched_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/ub_affine_sched_ctrl.sv
// Affine schedule controller for one unified-buffer port: walks a DIMS-deep loop
// nest and strobes valid_o when the cycle counter reaches offset + sum(stride_k * idx_k).
module ub_affine_sched_ctrl #(
    parameter int DIMS = 3,
    parameter int CW   = 16,
    parameter int TW   = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush_i,
    input  logic                 en_i,
    input  logic [DIMS*CW-1:0]   cfg_extent_i,
    input  logic [DIMS*TW-1:0]   cfg_stride_i,
    input  logic [TW-1:0]        cfg_offset_i,
    output logic                 valid_o,
    output logic [DIMS*CW-1:0]   ctrl_vars_o,
    output logic                 done_o,
    output logic                 sched_err_o
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   cycle_cnt_q, cycle_cnt_d;
    logic [CW-1:0]   idx_q    [DIMS];
    logic [CW-1:0]   idx_d    [DIMS];
    logic [TW-1:0]   t_q      [DIMS];
    logic [TW-1:0]   t_d      [DIMS];
    logic [CW-1:0]   ext_q    [DIMS];
    logic [CW-1:0]   ext_d    [DIMS];
    logic [TW-1:0]   stride_q [DIMS];
    logic [TW-1:0]   stride_d [DIMS];
    logic            sched_err_q, sched_err_d;

    logic [DIMS-1:0] can_inc;
    logic            due, late, fire, found;
    logic [TW-1:0]   t_adv;

    // An extent of 0 or 1 means the dimension never increments.
    generate
        for (genvar gi = 0; gi < DIMS; gi++) begin : g_dim
            assign can_inc[gi] = (ext_q[gi] > CW'(1)) && (idx_q[gi] < (ext_q[gi] - CW'(1)));
            assign ctrl_vars_o[gi*CW +: CW] = idx_q[gi];
        end
    endgenerate

    // A point whose time has already passed is fired immediately and flagged.
    assign due         = (cycle_cnt_q >= t_q[0]);
    assign late        = (cycle_cnt_q >  t_q[0]);
    assign fire        = (state_q == RUN) && en_i && due;
    assign valid_o     = fire;
    assign done_o      = (state_q == DONE);
    assign sched_err_o = sched_err_q;

    always_comb begin
        state_d     = state_q;
        cycle_cnt_d = cycle_cnt_q;
        idx_d       = idx_q;
        t_d         = t_q;
        ext_d       = ext_q;
        stride_d    = stride_q;
        sched_err_d = sched_err_q;
        found       = 1'b0;
        t_adv       = '0;

        if (flush_i) begin
            state_d     = RUN;
            cycle_cnt_d = '0;
            sched_err_d = 1'b0;
            for (int k = 0; k < DIMS; k++) begin
                idx_d[k]    = '0;
                t_d[k]      = cfg_offset_i;
                ext_d[k]    = cfg_extent_i[k*CW +: CW];
                stride_d[k] = cfg_stride_i[k*TW +: TW];
            end
        end else if ((state_q == RUN) && en_i) begin
            cycle_cnt_d = cycle_cnt_q + TW'(1);
            if (late) begin
                sched_err_d = 1'b1;
            end
            if (fire) begin
                // Odometer step: bump the lowest non-saturated dimension and
                // rebase every inner partial time on its updated time.
                for (int k = 0; k < DIMS; k++) begin
                    if (!found && can_inc[k]) begin
                        found    = 1'b1;
                        t_adv    = t_q[k] + stride_q[k];
                        idx_d[k] = idx_q[k] + CW'(1);
                        for (int j = 0; j <= k; j++) begin
                            t_d[j] = t_adv;
                        end
                        for (int j = 0; j < k; j++) begin
                            idx_d[j] = '0;
                        end
                    end
                end
                if (!found) begin
                    state_d = DONE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cycle_cnt_q <= '0;
            sched_err_q <= 1'b0;
            for (int k = 0; k < DIMS; k++) begin
                idx_q[k]    <= '0;
                t_q[k]      <= '0;
                ext_q[k]    <= '0;
                stride_q[k] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cycle_cnt_q <= cycle_cnt_d;
            sched_err_q <= sched_err_d;
            idx_q       <= idx_d;
            t_q         <= t_d;
            ext_q       <= ext_d;
            stride_q    <= stride_d;
        end
    end

endmodule

// File: tb/tb_ub_affine_sched_ctrl.sv
// Directed bench for ub_affine_sched_ctrl: records every fire (wall cycle after
// flush plus indices) and compares against hand-computed schedules.
module tb_ub_affine_sched_ctrl;

    localparam int DIMS = 3;
    localparam int CW   = 16;
    localparam int TW   = 32;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                flush_i;
    logic                en_i;
    logic [DIMS*CW-1:0]  cfg_extent_i;
    logic [DIMS*TW-1:0]  cfg_stride_i;
    logic [TW-1:0]       cfg_offset_i;
    logic                valid_o;
    logic [DIMS*CW-1:0]  ctrl_vars_o;
    logic                done_o;
    logic                sched_err_o;

    int chk_cnt = 0;
    int err_cnt = 0;
    int fcyc[$];
    int fidx0[$];
    int fidx1[$];
    int done_cyc;
    int err_cyc;

    ub_affine_sched_ctrl #(.DIMS(DIMS), .CW(CW), .TW(TW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush_i      (flush_i),
        .en_i         (en_i),
        .cfg_extent_i (cfg_extent_i),
        .cfg_stride_i (cfg_stride_i),
        .cfg_offset_i (cfg_offset_i),
        .valid_o      (valid_o),
        .ctrl_vars_o  (ctrl_vars_o),
        .done_o       (done_o),
        .sched_err_o  (sched_err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint obs, input longint exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge; the flush is captured by the following posedge and
    // the task returns at the negedge of cycle 0.
    task automatic do_flush(input logic [DIMS*CW-1:0] ext, input logic [DIMS*TW-1:0] str,
                            input logic [TW-1:0] off);
        cfg_extent_i = ext;
        cfg_stride_i = str;
        cfg_offset_i = off;
        flush_i      = 1'b1;
        @(negedge clk);
        flush_i      = 1'b0;
        cfg_extent_i = '0;
        cfg_stride_i = '0;
        cfg_offset_i = '0;
    endtask

    // Observe ncyc cycles; en is low for cycles en_lo..en_hi.
    task automatic run_capture(input int ncyc, input int en_lo, input int en_hi);
        fcyc.delete();
        fidx0.delete();
        fidx1.delete();
        done_cyc = -1;
        err_cyc  = -1;
        for (int c = 0; c < ncyc; c++) begin
            en_i = !(c >= en_lo && c <= en_hi);
            #1;
            if (valid_o) begin
                fcyc.push_back(c);
                fidx0.push_back(int'(ctrl_vars_o[0 +: CW]));
                fidx1.push_back(int'(ctrl_vars_o[CW +: CW]));
                $display("fire cycle=%0d idx0=%0d idx1=%0d idx2=%0d", c,
                         ctrl_vars_o[0 +: CW], ctrl_vars_o[CW +: CW], ctrl_vars_o[2*CW +: CW]);
            end
            if (done_o && done_cyc < 0) done_cyc = c;
            if (sched_err_o && err_cyc < 0) err_cyc = c;
            @(negedge clk);
        end
    endtask

    task automatic check_fires(input string tag, input int n, input int ec[4],
                               input int e0[4], input int e1[4]);
        check({tag, "_nfires"}, fcyc.size(), n);
        for (int i = 0; i < n && i < fcyc.size(); i++) begin
            check($sformatf("%s_cyc%0d", tag, i),  fcyc[i],  ec[i]);
            check($sformatf("%s_idx0_%0d", tag, i), fidx0[i], e0[i]);
            check($sformatf("%s_idx1_%0d", tag, i), fidx1[i], e1[i]);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_valid"}, valid_o, 0);
        check({tag, "_ctrl"},  ctrl_vars_o, 0);
        check({tag, "_done"},  done_o, 0);
        check({tag, "_err"},   sched_err_o, 0);
    endtask

    initial begin
        rst_n        = 1'b0;
        flush_i      = 1'b0;
        en_i         = 1'b1;
        cfg_extent_i = '0;
        cfg_stride_i = '0;
        cfg_offset_i = '0;
        repeat (2) @(negedge clk);
        check_idle("reset");
        rst_n = 1'b1;
        @(negedge clk);
        run_capture(5, -1, -2);
        check("idle_nfires", fcyc.size(), 0);
        check("idle_done", done_cyc, -1);

        // Single dimension of 4, extent 0 on dim 1 treated as 1.
        do_flush({16'd1, 16'd0, 16'd4}, {32'd0, 32'd0, 32'd1}, 32'd0);
        run_capture(8, -1, -2);
        check_fires("t1", 4, '{0, 1, 2, 3}, '{0, 1, 2, 3}, '{0, 0, 0, 0});
        check("t1_done", done_cyc, 4);
        check("t1_err", err_cyc, -1);

        // 2x2 nest, outer stride 64, offset 2.
        do_flush({16'd1, 16'd2, 16'd2}, {32'd0, 32'd64, 32'd1}, 32'd2);
        run_capture(75, -1, -2);
        check_fires("t2", 4, '{2, 3, 66, 67}, '{0, 1, 0, 1}, '{0, 0, 1, 1});
        check("t2_done", done_cyc, 68);
        check("t2_err", err_cyc, -1);

        // Same nest, en low in wall cycles 3..5 stalls the counter by 3.
        do_flush({16'd1, 16'd2, 16'd2}, {32'd0, 32'd64, 32'd1}, 32'd2);
        run_capture(75, 3, 5);
        check_fires("t3", 4, '{2, 6, 69, 70}, '{0, 1, 0, 1}, '{0, 0, 1, 1});
        check("t3_done", done_cyc, 71);
        check("t3_err", err_cyc, -1);

        // Zero strides: every point after the first is late.
        do_flush({16'd1, 16'd1, 16'd3}, {32'd0, 32'd0, 32'd0}, 32'd0);
        run_capture(6, -1, -2);
        check_fires("t4", 3, '{0, 1, 2, 0}, '{0, 1, 2, 0}, '{0, 0, 0, 0});
        check("t4_err", err_cyc, 2);
        check("t4_done", done_cyc, 3);

        // Flush at cycle 2 of a 4-point run with a new 2-point config.
        do_flush({16'd1, 16'd1, 16'd4}, {32'd0, 32'd0, 32'd1}, 32'd0);
        run_capture(2, -1, -2);
        check_fires("t5a", 2, '{0, 1, 0, 0}, '{0, 1, 0, 0}, '{0, 0, 0, 0});
        do_flush({16'd1, 16'd1, 16'd2}, {32'd0, 32'd0, 32'd1}, 32'd0);
        run_capture(6, -1, -2);
        check_fires("t5b", 2, '{0, 1, 0, 0}, '{0, 1, 0, 0}, '{0, 0, 0, 0});
        check("t5_done", done_cyc, 2);

        // Reset mid-run after sched_err has been raised.
        do_flush({16'd1, 16'd1, 16'd5}, {32'd0, 32'd0, 32'd0}, 32'd0);
        run_capture(3, -1, -2);
        check("t6_err_before", sched_err_o, 1);
        rst_n = 1'b0;
        #1;
        check_idle("t6_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_capture(6, -1, -2);
        check("t6_nfires", fcyc.size(), 0);
        check("t6_done", done_cyc, -1);
        check("t6_err", err_cyc, -1);

        $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
        $finish;
    end

endmodule
